// File: rtl/bus_arbiter_pkg.sv
// Shared types and bus widths for the two-master word-addressed bus arbiter.
// Imported by the arbiter top and its watchdog.
package bus_arbiter_pkg;

    localparam int ADDR_WIDTH = 30;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    // One master's request bundle, so both masters can share a single mux.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strobes;
        logic                  read;
        logic                  write;
    } bus_req_t;

    function automatic logic is_request(input bus_req_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Per-grant watchdog: counts granted cycles and flags the last one allowed
// before a transfer without s_ack is converted into a bus error.
module bus_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    assign expired = enable & (count == LAST_COUNT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between m0 (core) and m1 (DMA/debug).
// One transfer at a time; a watchdog turns a missing s_ack into a bus_error pulse.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_data_out,
    input  logic [STRB_WIDTH-1:0] m0_data_strobes,
    input  logic                  m0_read,
    input  logic                  m0_write,
    output logic [DATA_WIDTH-1:0] m0_data_in,
    output logic                  m0_ack,
    output logic                  m0_bus_error,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_data_out,
    input  logic [STRB_WIDTH-1:0] m1_data_strobes,
    input  logic                  m1_read,
    input  logic                  m1_write,
    output logic [DATA_WIDTH-1:0] m1_data_in,
    output logic                  m1_ack,
    output logic                  m1_bus_error,

    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [DATA_WIDTH-1:0] s_data_out,
    output logic [STRB_WIDTH-1:0] s_data_strobes,
    output logic                  s_read,
    output logic                  s_write,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_ack
);

    state_t   state;
    logic     last_grant;
    bus_req_t m0_req;
    bus_req_t m1_req;
    bus_req_t sel;
    logic     req0;
    logic     req1;
    logic     gnt0;
    logic     gnt1;
    logic     granted;
    logic     live;
    logic     proto_err;
    logic     expired;
    logic     exit_grant;
    logic     err;

    assign m0_req = {m0_address, m0_data_out, m0_data_strobes, m0_read, m0_write};
    assign m1_req = {m1_address, m1_data_out, m1_data_strobes, m1_read, m1_write};
    assign req0   = is_request(m0_req);
    assign req1   = is_request(m1_req);

    assign gnt0    = (state == ST_GRANT0);
    assign gnt1    = (state == ST_GRANT1);
    assign granted = gnt0 | gnt1;
    assign sel     = gnt1 ? m1_req : m0_req;

    // An abandoned grant (request dropped) drives nothing onto the slave.
    assign live      = granted & is_request(sel);
    assign proto_err = sel.read & sel.write;

    // Exit priority: ack, then timeout, then protocol error, then abandon.
    assign exit_grant = granted & (s_ack | expired | proto_err | ~is_request(sel));
    assign err        = granted & ~s_ack & (expired | proto_err);

    assign s_address      = live ? sel.address : '0;
    assign s_data_out     = live ? sel.data    : '0;
    assign s_data_strobes = live ? sel.strobes : '0;
    assign s_read         = live & sel.read  & ~proto_err;
    assign s_write        = live & sel.write & ~proto_err;

    assign m0_ack       = gnt0 & s_ack;
    assign m1_ack       = gnt1 & s_ack;
    assign m0_bus_error = gnt0 & err;
    assign m1_bus_error = gnt1 & err;
    assign m0_data_in   = gnt0 ? s_data_in : '0;
    assign m1_data_in   = gnt1 ? s_data_in : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || last_grant)) begin
                        state      <= ST_GRANT0;
                        last_grant <= 1'b0;
                    end else if (req1) begin
                        state      <= ST_GRANT1;
                        last_grant <= 1'b1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (exit_grant) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bus_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (~granted | exit_grant),
        .enable  (granted),
        .expired (expired)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single transfer, round-robin alternation, write path,
// watchdog timeout, protocol error and asynchronous reset mid-grant.
module tb_bus_arbiter;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] m0_address, m1_address, s_address;
    logic [31:0] m0_data_out, m1_data_out, s_data_out;
    logic [3:0]  m0_data_strobes, m1_data_strobes, s_data_strobes;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_data_in, m1_data_in, s_data_in;
    logic        m0_ack, m0_bus_error, m1_ack, m1_bus_error;
    logic        s_read, s_write, s_ack;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TIMEOUT_WIDTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .m0_address      (m0_address),
        .m0_data_out     (m0_data_out),
        .m0_data_strobes (m0_data_strobes),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_data_in      (m0_data_in),
        .m0_ack          (m0_ack),
        .m0_bus_error    (m0_bus_error),
        .m1_address      (m1_address),
        .m1_data_out     (m1_data_out),
        .m1_data_strobes (m1_data_strobes),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_data_in      (m1_data_in),
        .m1_ack          (m1_ack),
        .m1_bus_error    (m1_bus_error),
        .s_address       (s_address),
        .s_data_out      (s_data_out),
        .s_data_strobes  (s_data_strobes),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_data_in       (s_data_in),
        .s_ack           (s_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Every output of the block, for the all-zero checks.
    task automatic check_all_zero(input string tag);
        check({tag, "_s_addr"}, 64'(s_address), 64'd0);
        check({tag, "_s_data"}, 64'(s_data_out), 64'd0);
        check({tag, "_s_ctl"}, 64'({s_data_strobes, s_read, s_write}), 64'd0);
        check({tag, "_m0"}, 64'({m0_data_in, m0_ack, m0_bus_error}), 64'd0);
        check({tag, "_m1"}, 64'({m1_data_in, m1_ack, m1_bus_error}), 64'd0);
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_data_out = '0; m0_data_strobes = '0; m0_read = 0; m0_write = 0;
        m1_address = '0; m1_data_out = '0; m1_data_strobes = '0; m1_read = 0; m1_write = 0;
        s_data_in = '0; s_ack = 0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        tick();
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        check_all_zero(tag);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_who [4] = '{0, 1, 0, 1};
        reset = 1'b1;
        clear_inputs();

        // ---- single m0 read of byte 0x100 (word 0x40), ack on 2nd granted cycle
        do_reset("rst");
        m0_read = 1; m0_address = 30'h40; s_ack = 1;
        @(negedge clock);
        check("t1_idle_ack_ignored", 64'(m0_ack), 64'd0);
        check("t1_idle_sread", 64'(s_read), 64'd0);
        tick(); s_ack = 0;
        @(negedge clock);
        check("t1_g1_sread", 64'(s_read), 64'd1);
        check("t1_g1_saddr", 64'(s_address), 64'h40);
        check("t1_g1_ack", 64'(m0_ack), 64'd0);
        tick(); s_ack = 1; s_data_in = 32'hDEADBEEF;
        @(negedge clock);
        check("t1_g2_ack", 64'(m0_ack), 64'd1);
        check("t1_g2_data", 64'(m0_data_in), 64'hDEADBEEF);
        check("t1_g2_m1", 64'({m1_data_in, m1_ack}), 64'd0);
        tick(); s_ack = 0; m0_read = 0;
        @(negedge clock);
        check("t1_dead_sread", 64'(s_read), 64'd0);
        check("t1_dead_data", 64'(m0_data_in), 64'd0);

        // ---- both masters hold requests: m0, m1, m0, m1
        do_reset("rst2");
        m0_read = 1; m0_address = 30'h111;
        m1_read = 1; m1_address = 30'h222;
        @(negedge clock);
        check("t2_idle_sread", 64'(s_read), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); s_ack = 1; s_data_in = 32'hA000_0000 + 32'(k);
            @(negedge clock);
            check($sformatf("t2_x%0d_addr", k), 64'(s_address), exp_who[k] == 1 ? 64'h222 : 64'h111);
            check($sformatf("t2_x%0d_acks", k), 64'({m1_ack, m0_ack}), exp_who[k] == 1 ? 64'd2 : 64'd1);
            check($sformatf("t2_x%0d_data", k), 64'(exp_who[k] == 1 ? m1_data_in : m0_data_in),
                  64'hA000_0000 + 64'(k));
            tick(); s_ack = 0;
            @(negedge clock);
            check($sformatf("t2_x%0d_dead", k), 64'(s_read), 64'd0);
        end

        // ---- m1 write of byte 0x200 (word 0x80); m0 must see nothing
        do_reset("rst3");
        m1_write = 1; m1_address = 30'h80; m1_data_out = 32'h12345678; m1_data_strobes = 4'b0011;
        s_data_in = 32'h5555_AAAA;
        @(negedge clock);
        check("t3_idle_m0", 64'({m0_data_in, m0_ack, m0_bus_error}), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick(); s_ack = (c == 2);
            @(negedge clock);
            check($sformatf("t3_c%0d_addr", c), 64'(s_address), 64'h80);
            check($sformatf("t3_c%0d_data", c), 64'(s_data_out), 64'h12345678);
            check($sformatf("t3_c%0d_ctl", c), 64'({s_data_strobes, s_read, s_write}), 64'b0011_01);
            check($sformatf("t3_c%0d_m0", c), 64'({m0_data_in, m0_ack, m0_bus_error}), 64'd0);
            check($sformatf("t3_c%0d_m1ack", c), 64'(m1_ack), (c == 2) ? 64'd1 : 64'd0);
        end

        // ---- watchdog: no ack for TIMEOUT granted cycles
        do_reset("rst4");
        m0_read = 1; m0_address = 30'h10;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            @(negedge clock);
            check($sformatf("t4_c%0d_err", c), 64'(m0_bus_error), (c == TIMEOUT) ? 64'd1 : 64'd0);
            check($sformatf("t4_c%0d_sread", c), 64'(s_read), 64'd1);
        end
        tick();
        @(negedge clock);
        check("t4_after_sread", 64'(s_read), 64'd0);
        check("t4_after_err", 64'(m0_bus_error), 64'd0);

        // ---- same, but the slave acks on the timeout cycle: ack wins
        do_reset("rst5");
        m0_read = 1; m0_address = 30'h10;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick(); s_ack = (c == TIMEOUT);
            @(negedge clock);
        end
        check("t5_ack", 64'(m0_ack), 64'd1);
        check("t5_err", 64'(m0_bus_error), 64'd0);
        tick(); s_ack = 0; m0_read = 0;
        @(negedge clock);
        check("t5_dead", 64'({s_read, m0_ack}), 64'd0);

        // ---- protocol error: read and write together
        do_reset("rst6");
        m0_read = 1; m0_write = 1; m0_address = 30'h20;
        tick();
        @(negedge clock);
        check("t6_err", 64'(m0_bus_error), 64'd1);
        check("t6_strobes", 64'({s_read, s_write}), 64'd0);
        tick(); m0_read = 0; m0_write = 0;
        @(negedge clock);
        check("t6_after_err", 64'(m0_bus_error), 64'd0);

        // ---- asynchronous reset mid-grant, then m0 wins the first tie
        do_reset("rst7");
        m1_read = 1; m1_address = 30'h33; s_data_in = 32'hCAFE_F00D;
        tick();
        @(negedge clock);
        check("t7_granted_m1", 64'({s_read, m1_data_in}), {31'd0, 1'b1, 32'hCAFE_F00D});
        tick();
        #2 reset = 1'b1;
        #1;
        check_all_zero("t7_async");
        @(negedge clock);
        reset = 1'b0;
        m0_read = 1; m0_address = 30'h44;
        tick();
        @(negedge clock);
        check("t7_tie_addr", 64'(s_address), 64'h44);
        check("t7_tie_data", 64'({m0_data_in, m1_data_in}), {32'hCAFE_F00D, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
